vga_frame_monitor: RTL and testbench
====================================

# vga_frame_monitor

Receive-side checker for the 640x480 VGA output of `tt_um_vga_example`. It samples the 8-bit TinyVGA Pmod bus (`uo_out`) and recovers sync timing. It locks to the frame structure and produces a per-frame checksum and pixel count of the active area. It sits in the testbench or in loopback logic, so benches compare one checksum per frame instead of probing pixels.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_BP, 48, back-porch clocks from hsync deassert to first visible pixel
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines per frame
- V_BP, 33, hsync deasserts from vsync deassert to the deassert preceding line 0
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vga_in  in  8  Pmod bus: [0]R1 [1]G1 [2]B1 [3]VSYNC [4]R0 [5]G0 [6]B0 [7]HSYNC; both syncs active-low
- frame_done  out  1  one-cycle pulse when a complete frame's results are latched
- frame_sum  out  24  sum of active pixel values of last frame, mod 2^24
- pixel_count  out  19  active pixels counted in last frame
- h_period  out  12  last measured hsync-fall-to-fall period, in clocks
- v_lines  out  11  hsync falls counted in last frame
- timing_err  out  1  last frame had a timing mismatch
- locked  out  1  two consecutive clean frames seen

## Operation
- Input is registered twice (vga_q, vga_qq). All edges and pixels are taken from vga_q; an edge is vga_q≠vga_qq.
- Pixel value is 6 bits, {R1,R0,G1,G0,B1,B0}.
- hcnt (12b, saturates at 4095): cleared on hsync fall, otherwise increments. On each hsync fall, h_period ← hcnt+1. hcnt is not saturated when h_period is latched.
- hx (12b, saturating): 0 in the hsync-rise cycle, then increments.
- vy (11b, saturating): 0 on vsync rise; +1 on each hsync rise.
- Active window: H_BP ≤ hx < H_BP+H_ACTIVE, V_BP ≤ vy < V_BP+V_ACTIVE, and both syncs high in vga_q. In that window, the pixel value is added to sum_acc and pix_acc increments.
- vcnt: +1 per hsync fall. On vsync fall, vcnt is cleared. If an hsync fall coincides with the vsync fall, vcnt ← 1 and the coincident hsync fall counts toward the new frame.
- err_acc is set when an hsync fall latches a period ≠ H_TOTAL, except the first hsync fall after reset.
- States:
  - ARM (after reset): the first vsync fall moves to RUN, clears the accumulators and emits no frame_done. The partial frame is discarded.
  - RUN: each vsync fall latches frame_sum←sum_acc, pixel_count←pix_acc, v_lines←vcnt, timing_err←err_acc|(vcnt≠V_TOTAL)|(pix_acc≠H_ACTIVE·V_ACTIVE). It pulses frame_done and clears the accumulators.
- Lock: a 2-bit good-frame counter increments on each clean frame and saturates at 2. locked=1 when it is 2. A frame with timing_err clears the counter and locked in the same latch cycle.
- Asynchronous reset, at any point including mid-frame:
  - All outputs are 0.
  - Input registers, counters and accumulators are 0.
  - State returns to ARM.

## Timing
- Two-flop input path. frame_done, frame_sum, pixel_count, v_lines, timing_err and locked update 3 clock edges after the edge that first samples VSYNC=0 on vga_in. They are stable until the next frame_done.
- h_period updates on the same 3-edge latency after an HSYNC=0 sample.
- frame_done is exactly one cycle wide and never asserted in ARM.
- With ideal 640x480 timing, frame_done period = 420000 clocks.

## Test plan
- Reset then 4 ideal frames, all RGB bits 1:
  - First vsync fall gives no frame_done.
  - Each of the next 3 frame_done pulses shows frame_sum=0x275000, pixel_count=307200, v_lines=525, h_period=800 and timing_err=0.
  - locked rises at the 2nd frame_done and stays high.
- Ideal frames, black except pixel (0,0)=R1 only → frame_sum=32, pixel_count=307200.
- Locked stream, one line shortened to 799 clocks → that frame's frame_done shows timing_err=1 and h_period=799 after the short line. locked drops in the same cycle and returns after 2 clean frames.
- Frame with 524 lines → v_lines=524, timing_err=1, locked=0.
- rst_n pulsed low mid-frame:
  - All outputs go to 0 immediately.
  - The next vsync fall gives no frame_done.
  - The following complete frame reports correct values.
- Connect the `tt_um_vga_example` output to vga_in and run 3 frames → locked=1, timing_err=0, pixel_count=307200, and frame_sum identical on frames 2 and 3.

Source files
------------

// File: rtl/vga_frame_monitor_if.sv
// Pmod VGA bus into the frame monitor plus its per-frame result outputs.
// The source side drives vga_in; the monitor side produces the results.
interface vga_frame_monitor_if;
    logic [7:0]  vga_in;
    logic        frame_done;
    logic [23:0] frame_sum;
    logic [18:0] pixel_count;
    logic [11:0] h_period;
    logic [10:0] v_lines;
    logic        timing_err;
    logic        locked;

    modport master (
        output vga_in,
        input  frame_done, frame_sum, pixel_count, h_period, v_lines, timing_err, locked
    );

    modport slave (
        input  vga_in,
        output frame_done, frame_sum, pixel_count, h_period, v_lines, timing_err, locked
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// VGA receive checker: recovers sync timing, per-frame active-area checksum, pixel count and lock.
// Results update 3 edges after the edge that first samples a sync fall; input is never backpressured.
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_frame_monitor_if.slave  bus
);
    localparam logic [11:0] HX_LO = 12'(H_BP);
    localparam logic [11:0] HX_HI = 12'(H_BP + H_ACTIVE);
    localparam logic [10:0] VY_LO = 11'(V_BP);
    localparam logic [10:0] VY_HI = 11'(V_BP + V_ACTIVE);
    localparam logic [11:0] HT_L  = 12'(H_TOTAL);
    localparam logic [10:0] VT_L  = 11'(V_TOTAL);
    localparam logic [18:0] PIX_N = 19'(H_ACTIVE * V_ACTIVE);

    typedef enum logic {ARM, RUN} state_t;

    typedef struct packed {
        logic [5:0] pix;
        logic       hf;
        logic       hr;
        logic       vf;
        logic       vr;
        logic       sync_hi;
    } ev_t;

    state_t      state;
    logic [7:0]  vga_q;
    logic        hs_qq, vs_qq;
    ev_t         ev_c, ev1, ev2;
    logic [11:0] hcnt, hx, hx_cur, hper;
    logic [10:0] vy, vy_cur, vcnt;
    logic [23:0] sum_acc;
    logic [18:0] pix_acc;
    logic        err_acc, seen_hf, active, per_bad, frame_bad;
    logic [1:0]  good_cnt;

    logic        frame_done_r, timing_err_r, locked_r;
    logic [23:0] frame_sum_r;
    logic [18:0] pixel_count_r;
    logic [11:0] h_period_r;
    logic [10:0] v_lines_r;

    always_comb begin
        ev_c.pix     = {vga_q[0], vga_q[4], vga_q[1], vga_q[5], vga_q[2], vga_q[6]};
        ev_c.hf      = hs_qq & ~vga_q[7];
        ev_c.hr      = ~hs_qq & vga_q[7];
        ev_c.vf      = vs_qq & ~vga_q[3];
        ev_c.vr      = ~vs_qq & vga_q[3];
        ev_c.sync_hi = vga_q[7] & vga_q[3];
    end

    // Two event stages after edge detection align result updates to the 3-edge latency.
    always_comb begin
        hx_cur = ev2.hr ? 12'd0 : ((hx == 12'hfff) ? hx : hx + 12'd1);
        vy_cur = vy;
        if (ev2.vr)
            vy_cur = 11'd0;
        else if (ev2.hr && vy != 11'h7ff)
            vy_cur = vy + 11'd1;
        active    = ev2.sync_hi && hx_cur >= HX_LO && hx_cur < HX_HI &&
                    vy_cur >= VY_LO && vy_cur < VY_HI;
        hper      = hcnt + 12'd1;
        per_bad   = ev2.hf && seen_hf && hper != HT_L;
        frame_bad = err_acc || vcnt != VT_L || pix_acc != PIX_N;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARM;
            vga_q         <= '0;
            hs_qq         <= 1'b0;
            vs_qq         <= 1'b0;
            ev1           <= '0;
            ev2           <= '0;
            hcnt          <= '0;
            hx            <= '0;
            vy            <= '0;
            vcnt          <= '0;
            sum_acc       <= '0;
            pix_acc       <= '0;
            err_acc       <= 1'b0;
            seen_hf       <= 1'b0;
            good_cnt      <= '0;
            frame_done_r  <= 1'b0;
            frame_sum_r   <= '0;
            pixel_count_r <= '0;
            h_period_r    <= '0;
            v_lines_r     <= '0;
            timing_err_r  <= 1'b0;
            locked_r      <= 1'b0;
        end else begin
            vga_q        <= bus.vga_in;
            hs_qq        <= vga_q[7];
            vs_qq        <= vga_q[3];
            ev1          <= ev_c;
            ev2          <= ev1;
            hcnt         <= ev2.hf ? 12'd0 : ((hcnt == 12'hfff) ? hcnt : hcnt + 12'd1);
            hx           <= hx_cur;
            vy           <= vy_cur;
            frame_done_r <= 1'b0;
            if (ev2.hf) begin
                h_period_r <= hper;
                seen_hf    <= 1'b1;
            end
            if (ev2.vf) begin
                // A coincident hsync fall opens the new frame's line count.
                vcnt    <= {10'd0, ev2.hf};
                sum_acc <= '0;
                pix_acc <= '0;
                err_acc <= per_bad;
                if (state == ARM) begin
                    state <= RUN;
                end else begin
                    frame_done_r  <= 1'b1;
                    frame_sum_r   <= sum_acc;
                    pixel_count_r <= pix_acc;
                    v_lines_r     <= vcnt;
                    timing_err_r  <= frame_bad;
                    if (frame_bad) begin
                        good_cnt <= 2'd0;
                        locked_r <= 1'b0;
                    end else begin
                        if (good_cnt != 2'd2)
                            good_cnt <= good_cnt + 2'd1;
                        locked_r <= (good_cnt != 2'd0);
                    end
                end
            end else begin
                if (ev2.hf)
                    vcnt <= vcnt + 11'd1;
                if (per_bad)
                    err_acc <= 1'b1;
                if (active) begin
                    sum_acc <= sum_acc + {18'd0, ev2.pix};
                    pix_acc <= pix_acc + 19'd1;
                end
            end
        end
    end

    assign bus.frame_done  = frame_done_r;
    assign bus.frame_sum   = frame_sum_r;
    assign bus.pixel_count = pixel_count_r;
    assign bus.h_period    = h_period_r;
    assign bus.v_lines     = v_lines_r;
    assign bus.timing_err  = timing_err_r;
    assign bus.locked      = locked_r;
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a scaled-down raster; frames described by a table, pixels randomized.
module tb_vga_frame_monitor;
    localparam int HA = 8, HBP = 3, HT = 16, VA = 4, VBP = 2, VT = 9;
    localparam int HFP = 3, HSW = 2, VSW = 1;

    typedef struct {
        int pat;
        int nlines;
        int short_ln;
        bit rst_mid;
        bit exp_err;
        bit exp_lock;
    } row_t;

    typedef struct {
        int tick;
        int sum;
        int cnt;
        int vl;
        bit err;
        bit lock;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_frame_monitor_if bus ();

    vga_frame_monitor #(
        .H_ACTIVE(HA), .H_BP(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_BP(VBP), .V_TOTAL(VT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   tick_n = 0;
    exp_t expq[$];
    row_t tbl[15];
    bit   armed = 1'b0;
    int   f_sum, f_cnt, prev_sum, prev_cnt, prev_nl, prev_row;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (tick %0d)", name, act, exp_v, tick_n);
        end
    endtask

    function automatic logic [7:0] mk(input bit hs, input bit vs, input logic [5:0] p);
        return {hs, p[0], p[2], p[4], vs, p[1], p[3], p[5]};
    endfunction

    function automatic logic [5:0] pix_at(input int pat, input int x, input int y);
        case (pat)
            0:       return 6'h3f;
            1:       return (x == 0 && y == 0) ? 6'h20 : 6'h00;
            2:       return 6'($urandom_range(0, 63));
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] junk(input int pat);
        return (pat == 2) ? 6'($urandom_range(0, 63)) : 6'h00;
    endfunction

    task automatic tick(input logic [7:0] v);
        exp_t e;
        bus.vga_in = v;
        @(posedge clk);
        tick_n++;
        #1;
        if (expq.size() > 0 && expq[0].tick == tick_n) begin
            e = expq.pop_front();
            chk("frame_done", int'(bus.frame_done), 1);
            chk("frame_sum", int'(bus.frame_sum), e.sum);
            chk("pixel_count", int'(bus.pixel_count), e.cnt);
            chk("v_lines", int'(bus.v_lines), e.vl);
            chk("h_period", int'(bus.h_period), HT);
            chk("timing_err", int'(bus.timing_err), int'(e.err));
            chk("locked", int'(bus.locked), int'(e.lock));
        end else begin
            chk("frame_done_idle", int'(bus.frame_done), 0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_frame_sum"}, int'(bus.frame_sum), 0);
        chk({tag, "_pixel_count"}, int'(bus.pixel_count), 0);
        chk({tag, "_h_period"}, int'(bus.h_period), 0);
        chk({tag, "_v_lines"}, int'(bus.v_lines), 0);
        chk({tag, "_flags"}, int'({bus.frame_done, bus.timing_err, bus.locked}), 0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        #1 rst_n = 1'b1;
        armed = 1'b0;
        expq.delete();
    endtask

    // One raster line: visible span, front porch, hsync pulse, back porch.
    task automatic send_line(input bit vs, input int row, input int fp, input int pat, input bit chk_short);
        logic [5:0] p;
        for (int x = 0; x < HA; x++) begin
            if (row >= 0) begin
                p = pix_at(pat, x, row);
                f_sum += int'(p);
                f_cnt++;
            end else begin
                p = junk(pat);
            end
            tick(mk(1'b1, vs, p));
            if (chk_short && x == 2)
                chk("h_period_short", int'(bus.h_period), HT - 1);
        end
        for (int i = 0; i < fp + HSW + HBP; i++)
            tick(mk(!(i >= fp && i < fp + HSW), vs, junk(pat)));
    endtask

    // A frame starts at its vsync fall; that fall reports the previous frame.
    task automatic send_frame(input int r);
        row_t t;
        int   row;
        t = tbl[r];
        if (armed)
            expq.push_back('{tick_n + 4, prev_sum, prev_cnt, prev_nl,
                             tbl[prev_row].exp_err, tbl[prev_row].exp_lock});
        armed = 1'b1;
        f_sum = 0;
        f_cnt = 0;
        for (int ln = 0; ln < t.nlines; ln++) begin
            if (t.rst_mid && ln == VSW + VBP + 1)
                pulse_reset();
            row = (ln >= VSW + VBP && ln < VSW + VBP + VA) ? ln - VSW - VBP : -1;
            send_line(ln >= VSW, row, (ln == t.short_ln) ? HFP - 1 : HFP, t.pat,
                      t.short_ln >= 0 && ln == t.short_ln + 1);
        end
        prev_sum = f_sum % (1 << 24);
        prev_cnt = f_cnt;
        prev_nl  = t.nlines;
        prev_row = r;
    endtask

    initial begin
        // pat: 0 all ones, 1 only pixel (0,0)=R1, 2 random, 3 black
        tbl[0]  = '{0, VT,     -1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{0, VT,     -1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{0, VT,     -1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1, VT,     -1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2, VT,     -1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{2, VT,      5, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2, VT,     -1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2, VT,     -1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{0, VT - 1, -1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2, VT,     -1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2, VT,     -1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2, VT,     -1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{3, VT,     -1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{2, VT,     -1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{0, VT,     -1, 1'b0, 1'b0, 1'b0};

        bus.vga_in = 8'h00;
        #12;
        check_zero("reset");
        rst_n = 1'b1;

        send_line(1'b1, -1, HFP, 3, 1'b0);
        for (int r = 0; r < 15; r++)
            send_frame(r);
        chk("pending_frame_done", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
